// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, PC-relative branch target and run sequencing.
// Ports: clk, rst_n, start, halt, stall, br_taken, br_sel -> lut_idx,
//        lut_val (signed offset in), pc, running, done, fault, cycle_cnt.
module pc_branch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 1023,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [2:0]       br_sel,
    output logic [2:0]       lut_idx,
    input  logic [7:0]       lut_val,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    // Compared at 32 bits so a LAST_ADDR beyond the PC range never faults.
    localparam logic [31:0]     LAST_PC  = 32'(LAST_ADDR);

    state_t           state;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  next_pc;
    logic             past_end;
    logic [CNT_W-1:0] cnt_inc;

    assign lut_idx = br_sel;

    always_comb begin
        // Sign-extend the LUT offset; the add wraps modulo 2**PC_W.
        offset   = PC_W'($signed(lut_val));
        next_pc  = br_taken ? pc + offset : pc + PC_W'(1);
        past_end = 32'(next_pc) > LAST_PC;
        cnt_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= START_PC;
            cycle_cnt <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            unique case (state)
                S_RUN: begin
                    cycle_cnt <= cnt_inc;
                    if (halt) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        if (past_end) begin
                            // pc keeps the address of the faulting fetch source
                            state   <= S_FAULT;
                            running <= 1'b0;
                            fault   <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state     <= S_RUN;
                        pc        <= START_PC;
                        cycle_cnt <= '0;
                        running   <= 1'b1;
                        done      <= 1'b0;
                        fault     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed vectors with a queued scoreboard and monitor.
// Unit 0 uses LAST_ADDR=1023, unit 1 uses LAST_ADDR=200; inputs are shared.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [2:0]  br_sel = 3'd0;
    logic [7:0]  lut_val = 8'd0;

    logic [2:0]  idx0, idx1;
    logic [9:0]  pc0, pc1;
    logic        run0, run1, done0, done1, flt0, flt1;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          u;
        logic [9:0]  pc;
        logic [2:0]  fl;
        logic [15:0] cnt;
        logic [2:0]  idx;
        string       tag;
    } exp_t;

    exp_t q[$];

    localparam logic [2:0] F_IDLE = 3'b000;
    localparam logic [2:0] F_RUN  = 3'b100;
    localparam logic [2:0] F_DONE = 3'b010;
    localparam logic [2:0] F_FLT  = 3'b001;

    always #5 clk = ~clk;

    pc_branch_unit #(.PC_W(10), .START_ADDR(0), .LAST_ADDR(1023), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .br_taken(br_taken), .br_sel(br_sel), .lut_idx(idx0), .lut_val(lut_val),
        .pc(pc0), .running(run0), .done(done0), .fault(flt0), .cycle_cnt(cnt0)
    );

    pc_branch_unit #(.PC_W(10), .START_ADDR(0), .LAST_ADDR(200), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .br_taken(br_taken), .br_sel(br_sel), .lut_idx(idx1), .lut_val(lut_val),
        .pc(pc1), .running(run1), .done(done1), .fault(flt1), .cycle_cnt(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_unit(input exp_t e);
        if (e.u == 0) begin
            check({e.tag, " pc"}, 32'(pc0), 32'(e.pc));
            check({e.tag, " flags"}, 32'({run0, done0, flt0}), 32'(e.fl));
            check({e.tag, " cnt"}, 32'(cnt0), 32'(e.cnt));
            check({e.tag, " idx"}, 32'(idx0), 32'(e.idx));
        end else begin
            check({e.tag, " pc"}, 32'(pc1), 32'(e.pc));
            check({e.tag, " flags"}, 32'({run1, done1, flt1}), 32'(e.fl));
            check({e.tag, " cnt"}, 32'(cnt1), 32'(e.cnt));
            check({e.tag, " idx"}, 32'(idx1), 32'(e.idx));
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                check_unit(q.pop_front());
            end
        end
    end

    task automatic step(input string tag, input int u, input logic s,
                        input logic h, input logic st, input logic b,
                        input logic [2:0] sel, input logic [7:0] lv,
                        input logic [9:0] epc, input logic [2:0] efl,
                        input logic [15:0] ecnt);
        exp_t e;
        @(negedge clk);
        start    = s;
        halt     = h;
        stall    = st;
        br_taken = b;
        br_sel   = sel;
        lut_val  = lv;
        e.u   = u;
        e.pc  = epc;
        e.fl  = efl;
        e.cnt = ecnt;
        e.idx = sel;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        halt     = 1'b0;
        stall    = 1'b0;
        br_taken = 1'b0;
        br_sel   = 3'd0;
        lut_val  = 8'd0;
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        #1;
        e = '{0, 10'd0, F_IDLE, 16'd0, 3'd0, "reset0"};
        check_unit(e);
        e.u = 1; e.tag = "reset1";
        check_unit(e);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: start then sequential fetch; start inside RUN is ignored
        step("start", 0, 1, 0, 0, 0, 3'd0, 8'h00, 10'd0, F_RUN, 16'd0);
        step("seq1", 0, 0, 0, 0, 0, 3'd1, 8'h00, 10'd1, F_RUN, 16'd1);
        step("seq2", 0, 1, 0, 0, 0, 3'd2, 8'h00, 10'd2, F_RUN, 16'd2);
        step("seq3", 0, 0, 0, 0, 0, 3'd3, 8'h7f, 10'd3, F_RUN, 16'd3);
        step("seq4", 0, 0, 0, 0, 0, 3'd4, 8'h00, 10'd4, F_RUN, 16'd4);
        step("seq5", 0, 0, 0, 0, 0, 3'd5, 8'h00, 10'd5, F_RUN, 16'd5);

        // 2: forward to 40, then back by -30
        step("br+35", 0, 0, 0, 0, 1, 3'd6, 8'h23, 10'd40, F_RUN, 16'd6);
        step("br-30", 0, 0, 0, 0, 1, 3'd5, 8'hE2, 10'd10, F_RUN, 16'd7);

        // 3: wrap below zero and past the top of the PC range
        step("br-7", 0, 0, 0, 0, 1, 3'd7, 8'hF9, 10'd3, F_RUN, 16'd8);
        step("wrapneg", 0, 0, 0, 0, 1, 3'd2, 8'hFB, 10'd1022, F_RUN, 16'd9);
        step("to1023", 0, 0, 0, 0, 0, 3'd0, 8'h00, 10'd1023, F_RUN, 16'd10);
        step("wrappos", 0, 0, 0, 0, 0, 3'd0, 8'h00, 10'd0, F_RUN, 16'd11);

        // 5: stall beats branch; halt beats stall and branch
        step("br+7", 0, 0, 0, 0, 1, 3'd1, 8'h07, 10'd7, F_RUN, 16'd12);
        step("stall", 0, 0, 0, 1, 1, 3'd3, 8'h05, 10'd7, F_RUN, 16'd13);
        step("halt", 0, 0, 1, 1, 1, 3'd4, 8'h05, 10'd7, F_DONE, 16'd14);
        step("frozen", 0, 0, 0, 0, 1, 3'd2, 8'h05, 10'd7, F_DONE, 16'd14);
        step("self", 0, 0, 0, 0, 0, 3'd0, 8'h00, 10'd7, F_DONE, 16'd14);

        // 6: restart from DONE, self-loop, go to 33, async reset between edges
        step("restart", 0, 1, 0, 0, 0, 3'd0, 8'h00, 10'd0, F_RUN, 16'd0);
        step("loop0", 0, 0, 0, 0, 1, 3'd0, 8'h00, 10'd0, F_RUN, 16'd1);
        step("br+33", 0, 0, 0, 0, 1, 3'd1, 8'h21, 10'd33, F_RUN, 16'd2);
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        e = '{0, 10'd0, F_IDLE, 16'd0, 3'd0, "asyncrst"};
        check_unit(e);
        @(negedge clk);
        rst_n = 1'b1;

        // 4: unit 1 with LAST_ADDR=200 faults on 150+100
        step("u1start", 1, 1, 0, 0, 0, 3'd0, 8'h00, 10'd0, F_RUN, 16'd0);
        step("u1br100", 1, 0, 0, 0, 1, 3'd1, 8'h64, 10'd100, F_RUN, 16'd1);
        step("u1br50", 1, 0, 0, 0, 1, 3'd2, 8'h32, 10'd150, F_RUN, 16'd2);
        step("u1fault", 1, 0, 0, 0, 1, 3'd3, 8'h64, 10'd150, F_FLT, 16'd3);
        step("u1frozen", 1, 0, 0, 0, 0, 3'd0, 8'h00, 10'd150, F_FLT, 16'd3);
        step("u1restart", 1, 1, 0, 0, 0, 3'd0, 8'h00, 10'd0, F_RUN, 16'd0);
        step("u1seq", 1, 0, 0, 0, 0, 3'd0, 8'h00, 10'd1, F_RUN, 16'd1);
        step("u1br200", 1, 0, 0, 0, 1, 3'd0, 8'h63, 10'd100, F_RUN, 16'd2);
        step("u1edge", 1, 0, 0, 0, 1, 3'd0, 8'h64, 10'd200, F_RUN, 16'd3);
        step("u1over", 1, 0, 0, 0, 0, 3'd0, 8'h00, 10'd200, F_FLT, 16'd4);

        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
